menu_order_scheduler: RTL and testbench
=======================================

// Module: menu_order_scheduler
// PURPOSE
// - Sits behind the menu FSM: takes the one-hot selection (OP1..OP4), queues it as an order,
//   and pulses CLC so the menu returns to M1.
// - Shares one preparation resource (kitchen/dispenser) through a req/ack/done handshake,
//   one order at a time, in FIFO order, with a watchdog on preparation.
// PARAMETERS
// - FIFO_DEPTH    4     order queue depth, power of 2, >= 2
// - PREP_TIMEOUT  1000  max cycles in PREP waiting for srv_done before abandoning the order
// - TW            10    timer width; must hold PREP_TIMEOUT-1
// PORTS
// - clk          in   1   clock
// - reset        in   1   asynchronous, active-high reset
// - op_sel       in   4   menu outputs {OP4,OP3,OP2,OP1}, one-hot or zero
// - clc          out  1   1-cycle pulse to menu CLC input: order accepted
// - srv_req      out  1   request to resource, held until srv_ack
// - srv_item     out  2   item code of the head order (0=OP1..3=OP4), valid while srv_req
// - srv_ack      in   1   resource accepted the request
// - srv_done     in   1   resource finished the current order
// - err_clr      in   1   clears timeout_err
// - fifo_count   out  $clog2(FIFO_DEPTH)+1   queued orders, not counting the one in service
// - fifo_full    out  1   fifo_count == FIFO_DEPTH
// - busy         out  1   FSM not in IDLE
// - timeout_err  out  1   sticky: a preparation timed out
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, FSM IDLE, timer 0, arm flag 1.
// - Capture: at the clock edge where op_sel is exactly one-hot, arm=1 and !fifo_full:
//   push the encoded item, clear arm, assert clc for exactly the next cycle.
// - arm returns to 1 at the first edge where op_sel==0. This prevents a double push while
//   the menu is still leaving its S state.
// - op_sel with more than one bit set: ignored, no push, no clc.
// - FIFO full: no push and no clc. The menu stays in its S state until space frees
//   (natural backpressure).
// - Full blocks a push even if a pop happens in the same cycle.
// - Push and pop in the same cycle when not full: fifo_count unchanged, order preserved.
// - Dispatch FSM:
//   - IDLE -> REQ when FIFO not empty.
//   - REQ: srv_req=1, srv_item=head. On srv_ack: pop head, clear timer, go to PREP.
//     REQ has no timeout.
//   - PREP: srv_req=0, timer increments each cycle.
//     - srv_done -> IDLE.
//     - Else, when timer == PREP_TIMEOUT-1: set timeout_err, abandon the order, go to IDLE.
//     - srv_done on the timeout cycle wins: no error.
//   - srv_done in IDLE or REQ is ignored. srv_ack outside REQ is ignored.
// - Latency from an empty, idle state:
//   - op_sel valid at edge N: clc=1 and fifo_count=1 during cycle N..N+1.
//   - srv_req=1 one cycle later.
//   - srv_ack sampled at an edge: srv_req drops and the pop is visible after that edge.
// - timeout_err: set has priority over err_clr in the same cycle.
// - Reset mid-operation: the queue and the in-service order are discarded; srv_req drops immediately.
// STRUCTURE
// - Shared package menu_pkg:
//   - item codes ITEM_OP1..ITEM_OP4 = 2'd0..2'd3
//   - dispatch state enum {IDLE, REQ, PREP}
//   - onehot-to-code function
// - Sub-module order_fifo: synchronous FIFO, params DEPTH and W=2.
//   - push, pop, din, dout (show-ahead), count, full, empty; async active-high reset.
//   - Pointer wrap via extra MSB.
// - Top level holds capture/arm logic, dispatch FSM, watchdog timer, error flag.
// TESTING
// - Single order:
//   - op_sel=0010, held until clc, then 0.
//   - Expect: one clc pulse, srv_req with srv_item=1.
//   - srv_ack, then 5 cycles later srv_done: busy returns to 0, fifo_count=0, timeout_err=0.
// - Backpressure (srv_ack held low, FIFO_DEPTH=4):
//   - Issue OP1, OP2, OP3, OP4, OP1.
//   - Expect: 4 clc pulses, fifo_full=1 after the 4th; 5th op_sel held with no clc.
//   - One srv_ack: 5th order accepted next edge.
//   - Expect srv_item sequence 0,1,2,3,0.
// - Timeout (PREP_TIMEOUT=8):
//   - Ack, then no done: timeout_err=1 exactly 8 cycles after entering PREP, FSM back to IDLE.
//   - err_clr pulse clears it.
//   - Also: done on the 8th cycle -> no error.
// - Simultaneous push/pop: push at the same edge srv_ack pops, fifo_count=2 -> stays 2, order kept.
// - Invalid selection: op_sel=0101 for 10 cycles -> no clc, fifo_count stays 0.
// - Reset mid-PREP with 3 queued: all outputs 0 at once.
//   - After release, a new OP3 is served first with srv_item=2.

Source files
------------

// File: rtl/menu_pkg.sv
// Shared types and helpers for the menu order path: item codes, dispatch states,
// and the one-hot selection encoder.
package menu_pkg;

    localparam logic [1:0] ITEM_OP1 = 2'd0;
    localparam logic [1:0] ITEM_OP2 = 2'd1;
    localparam logic [1:0] ITEM_OP3 = 2'd2;
    localparam logic [1:0] ITEM_OP4 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        PREP = 2'd2
    } dispatch_state_t;

    function automatic logic [1:0] onehot_to_code(input logic [3:0] sel);
        logic [1:0] code;
        code = ITEM_OP1;
        case (sel)
            4'b0001: code = ITEM_OP1;
            4'b0010: code = ITEM_OP2;
            4'b0100: code = ITEM_OP3;
            4'b1000: code = ITEM_OP4;
            default: code = ITEM_OP1;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/order_fifo.sv
// Show-ahead synchronous FIFO for queued orders; pointers carry an extra MSB so
// full and empty are told apart without a separate flag.
module order_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_din,
    output logic [W-1:0]             o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_count   = r_wr - r_rd;
    assign o_full    = (o_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_wr == r_rd);
    assign o_dout    = r_mem[r_rd[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read between the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/menu_order_scheduler.sv
// Queues menu selections as orders and serves them one at a time through a
// req/ack/done handshake with a watchdog on the preparation phase.
module menu_order_scheduler
    import menu_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int PREP_TIMEOUT = 1000,
    parameter int TW           = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    op_sel,
    output logic                          clc,
    output logic                          srv_req,
    output logic [1:0]                    srv_item,
    input  logic                          srv_ack,
    input  logic                          srv_done,
    input  logic                          err_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          busy,
    output logic                          timeout_err,
    output dispatch_state_t               dbg_state
);

    // Handshake: srv_req is held while in REQ; the order is handed over at the
    // edge where srv_req and srv_ack are both 1. srv_done closes it from PREP.

    dispatch_state_t r_state;
    dispatch_state_t w_next;
    logic            r_arm;
    logic            r_clc;
    logic            r_err;
    logic [TW-1:0]   r_timer;
    logic            w_onehot;
    logic            w_push;
    logic            w_pop;
    logic            w_timeout;
    logic            w_empty;
    logic [1:0]      w_head;

    assign w_onehot = (op_sel != 4'd0) && ((op_sel & (op_sel - 4'd1)) == 4'd0);
    assign w_push   = w_onehot && r_arm && !fifo_full;

    order_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (onehot_to_code(op_sel)),
        .o_dout  (w_head),
        .o_count (fifo_count),
        .o_full  (fifo_full),
        .o_empty (w_empty)
    );

    // arm stays low after a capture until the menu has released op_sel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arm <= 1'b1;
            r_clc <= 1'b0;
        end else begin
            r_clc <= w_push;
            if (w_push)
                r_arm <= 1'b0;
            else if (op_sel == 4'd0)
                r_arm <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: if (!w_empty) w_next = REQ;
            REQ: begin
                if (srv_ack) begin
                    w_pop  = 1'b1;
                    w_next = PREP;
                end
            end
            PREP: begin
                if (srv_done) begin
                    w_next = IDLE;
                end else if (r_timer == TW'(PREP_TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Timer counts only while in PREP, so entering PREP always starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == PREP) r_timer <= r_timer + 1'b1;
            else                 r_timer <= '0;
            if (w_timeout)    r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end

    assign clc         = r_clc;
    assign srv_req     = (r_state == REQ);
    assign srv_item    = srv_req ? w_head : ITEM_OP1;
    assign busy        = (r_state != IDLE);
    assign timeout_err = r_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_menu_order_scheduler.sv
// Directed bench for menu_order_scheduler: capture, backpressure, watchdog,
// push/pop overlap, invalid selection and mid-operation reset.
module tb_menu_order_scheduler;
    import menu_pkg::*;

    logic            clk;
    logic            reset;
    logic [3:0]      op_sel;
    logic            clc;
    logic            srv_req;
    logic [1:0]      srv_item;
    logic            srv_ack;
    logic            srv_done;
    logic            err_clr;
    logic [2:0]      fifo_count;
    logic            fifo_full;
    logic            busy;
    logic            timeout_err;
    dispatch_state_t dbg_state;

    int         n_checks;
    int         n_errors;
    logic [1:0] exp_q[$];

    menu_order_scheduler #(
        .FIFO_DEPTH   (4),
        .PREP_TIMEOUT (8),
        .TW           (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op_sel      (op_sel),
        .clc         (clc),
        .srv_req     (srv_req),
        .srv_item    (srv_item),
        .srv_ack     (srv_ack),
        .srv_done    (srv_done),
        .err_clr     (err_clr),
        .fifo_count  (fifo_count),
        .fifo_full   (fifo_full),
        .busy        (busy),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clc(input string tag);
        int n;
        n = 0;
        while (!clc && n < 20) begin
            step();
            n++;
        end
        check(tag, 32'(clc), 32'd1);
    endtask

    // Present a selection, wait for its clc, release it and record the item.
    task automatic issue(input logic [3:0] sel, input logic [1:0] code);
        op_sel = sel;
        wait_clc("issue_clc");
        if (clc) exp_q.push_back(code);
        op_sel = 4'd0;
        step();
        check("clc_single_pulse", 32'(clc), 32'd0);
    endtask

    task automatic do_req();
        int n;
        logic [1:0] exp_item;
        n = 0;
        while (!srv_req && n < 20) begin
            step();
            n++;
        end
        check("srv_req_seen", 32'(srv_req), 32'd1);
        exp_item = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd0;
        check("srv_item", 32'(srv_item), 32'(exp_item));
        srv_ack = 1'b1;
        step();
        srv_ack = 1'b0;
        check("srv_req_drop", 32'(srv_req), 32'd0);
    endtask

    task automatic do_done();
        srv_done = 1'b1;
        step();
        srv_done = 1'b0;
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        logic clc_seen;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        op_sel   = 4'd0;
        srv_ack  = 1'b0;
        srv_done = 1'b0;
        err_clr  = 1'b0;
        repeat (3) step();
        check("rst_clc", 32'(clc), 32'd0);
        check("rst_srv_req", 32'(srv_req), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(timeout_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        step();

        // Single order: OP2 -> item 1, done five cycles after ack.
        op_sel = 4'b0010;
        wait_clc("single_clc");
        check("single_count", 32'(fifo_count), 32'd1);
        exp_q.push_back(2'd1);
        op_sel = 4'd0;
        step();
        check("single_clc_off", 32'(clc), 32'd0);
        check("single_req", 32'(srv_req), 32'd1);
        do_req();
        check("single_count_pop", 32'(fifo_count), 32'd0);
        repeat (4) step();
        do_done();
        check("single_count_end", 32'(fifo_count), 32'd0);
        check("single_err", 32'(timeout_err), 32'd0);

        // Backpressure: four orders fill the queue, the fifth waits for space.
        issue(4'b0001, 2'd0);
        check("bp_count1", 32'(fifo_count), 32'd1);
        issue(4'b0010, 2'd1);
        check("bp_count2", 32'(fifo_count), 32'd2);
        issue(4'b0100, 2'd2);
        check("bp_count3", 32'(fifo_count), 32'd3);
        issue(4'b1000, 2'd3);
        check("bp_count4", 32'(fifo_count), 32'd4);
        check("bp_full", 32'(fifo_full), 32'd1);
        op_sel = 4'b0001;
        clc_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (clc) clc_seen = 1'b1;
        end
        check("bp_no_clc_when_full", 32'(clc_seen), 32'd0);
        do_req();
        check("bp_blocked_on_pop_edge", 32'(clc), 32'd0);
        check("bp_count_after_pop", 32'(fifo_count), 32'd3);
        step();
        check("bp_fifth_clc", 32'(clc), 32'd1);
        check("bp_fifth_count", 32'(fifo_count), 32'd4);
        exp_q.push_back(2'd0);
        op_sel = 4'd0;
        for (int i = 0; i < 4; i++) begin
            do_done();
            do_req();
        end
        do_done();
        check("bp_drained", 32'(fifo_count), 32'd0);
        check("bp_exp_empty", 32'(exp_q.size()), 32'd0);

        // Watchdog: no done -> error on the 8th PREP cycle; set beats err_clr.
        issue(4'b0100, 2'd2);
        do_req();
        repeat (7) step();
        check("to_err_before", 32'(timeout_err), 32'd0);
        check("to_busy_before", 32'(busy), 32'd1);
        err_clr = 1'b1;
        step();
        check("to_err_set", 32'(timeout_err), 32'd1);
        check("to_idle", 32'(busy), 32'd0);
        step();
        err_clr = 1'b0;
        check("to_err_cleared", 32'(timeout_err), 32'd0);

        // Done on the timeout cycle wins.
        issue(4'b1000, 2'd3);
        do_req();
        repeat (7) step();
        do_done();
        check("to_done_wins", 32'(timeout_err), 32'd0);

        // Push and pop on the same edge with two queued.
        issue(4'b0001, 2'd0);
        issue(4'b0010, 2'd1);
        check("pp_count_before", 32'(fifo_count), 32'd2);
        check("pp_req", 32'(srv_req), 32'd1);
        check("pp_head", 32'(srv_item), 32'(exp_q.pop_front()));
        op_sel  = 4'b0100;
        srv_ack = 1'b1;
        step();
        srv_ack = 1'b0;
        check("pp_clc", 32'(clc), 32'd1);
        check("pp_count_after", 32'(fifo_count), 32'd2);
        exp_q.push_back(2'd2);
        op_sel = 4'd0;
        step();
        do_done();
        do_req();
        do_done();
        do_req();
        do_done();
        check("pp_drained", 32'(fifo_count), 32'd0);

        // Invalid multi-hot selection is ignored.
        op_sel = 4'b0101;
        clc_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (clc) clc_seen = 1'b1;
        end
        check("inv_no_clc", 32'(clc_seen), 32'd0);
        check("inv_count", 32'(fifo_count), 32'd0);
        op_sel = 4'd0;
        step();

        // Reset in PREP with three orders queued.
        issue(4'b0010, 2'd1);
        issue(4'b0100, 2'd2);
        issue(4'b1000, 2'd3);
        issue(4'b0001, 2'd0);
        do_req();
        check("mr_count3", 32'(fifo_count), 32'd3);
        check("mr_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mr_count0", 32'(fifo_count), 32'd0);
        check("mr_busy0", 32'(busy), 32'd0);
        check("mr_full0", 32'(fifo_full), 32'd0);
        check("mr_req0", 32'(srv_req), 32'd0);
        check("mr_item0", 32'(srv_item), 32'd0);
        exp_q.delete();
        step();
        reset = 1'b0;
        step();
        issue(4'b0100, 2'd2);
        do_req();
        do_done();
        check("mr_final_count", 32'(fifo_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule
